// File: rtl/music_sheet_pkg.sv
// rtl/music_sheet_pkg.sv - shared constants and types for the music sheet sequencer
package music_sheet_pkg;

   localparam logic [1:0] ADDR_NOTE = 2'd0;
   localparam logic [1:0] ADDR_CTRL = 2'd1;
   localparam logic [1:0] ADDR_DIV  = 2'd2;
   localparam logic [1:0] ADDR_STAT = 2'd3;

   localparam int CTRL_RUN    = 0;
   localparam int CTRL_FLUSH  = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam int STAT_EMPTY     = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_PLAYING   = 2;
   localparam int STAT_OVERFLOW  = 3;
   localparam int STAT_COUNT_LSB = 8;

   localparam int NOTE_LSB = 0;
   localparam int NOTE_MSB = 7;
   localparam int DUR_LSB  = 8;
   localparam int DUR_MSB  = 23;
   localparam int ENTRY_W  = 24;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY, ST_GAP} seq_state_t;

endpackage

// File: rtl/music_sheet_fifo.sv
// rtl/music_sheet_fifo.sv - synchronous note FIFO with flush and drop reporting
module music_sheet_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 24
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty & ~flush;
   // a pop in the same cycle frees the slot the push needs
   assign push_ok = push & ~flush & (~full | pop_ok);
   assign dropped = push & ~flush & ~push_ok;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/music_sheet_sequencer.sv
// rtl/music_sheet_sequencer.sv - Avalon-MM note queue that plays notes, rests and gaps on a tick
module music_sheet_sequencer
   import music_sheet_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int TICK_W      = 24,
   parameter int DEFAULT_DIV = 50000,
   parameter int GAP_TICKS   = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  note_out,
   output logic        note_on,
   output logic        note_strobe,
   output logic        irq
);

   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int DUR_W = DUR_MSB - DUR_LSB + 1;
   localparam int GAP_W = 16;

   seq_state_t         state, state_n;
   logic               run, irq_en, overflow;
   logic [TICK_W-1:0]  div, div_eff, presc_cnt, presc_n;
   logic [DUR_W-1:0]   dur_cnt, dur_n;
   logic [GAP_W-1:0]   gap_cnt, gap_n;
   logic [7:0]         note_out_n;
   logic               note_on_n;
   logic               wr, wr_note, wr_ctrl, wr_div, wr_stat;
   logic               flush_now, eff_run, abort, tick, pop, seq_done;
   logic [ENTRY_W-1:0] fifo_head;
   logic [CW-1:0]      fifo_count;
   logic               fifo_full, fifo_empty, fifo_dropped;
   logic [7:0]         head_note;
   logic [DUR_W-1:0]   head_dur;
   logic               unused_wdata;

   assign wr      = chipselect & ~write_n;
   assign wr_note = wr & (address == ADDR_NOTE);
   assign wr_ctrl = wr & (address == ADDR_CTRL);
   assign wr_div  = wr & (address == ADDR_DIV);
   assign wr_stat = wr & (address == ADDR_STAT);

   assign unused_wdata = &{1'b0, writedata[31:ENTRY_W]};

   // a CTRL write takes effect on the sequencer in the same cycle it is issued
   assign flush_now = wr_ctrl & writedata[CTRL_FLUSH];
   assign eff_run   = wr_ctrl ? writedata[CTRL_RUN] : run;
   assign abort     = (state != ST_IDLE) & (~eff_run | flush_now);

   assign div_eff = (div == '0) ? TICK_W'(1) : div;
   assign tick    = (presc_cnt >= div_eff - 1'b1);

   assign head_note = fifo_head[NOTE_MSB:NOTE_LSB];
   assign head_dur  = fifo_head[DUR_MSB:DUR_LSB];

   assign irq = irq_en & fifo_empty & (state == ST_IDLE);

   music_sheet_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (wr_note),
      .push_data (writedata[ENTRY_W-1:0]),
      .pop       (pop),
      .flush     (flush_now),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .dropped   (fifo_dropped)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run      <= 1'b0;
         irq_en   <= 1'b0;
         div      <= TICK_W'(DEFAULT_DIV);
         overflow <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            run    <= writedata[CTRL_RUN];
            irq_en <= writedata[CTRL_IRQ_EN];
         end
         if (wr_div) div <= writedata[TICK_W-1:0];
         if (wr_stat)           overflow <= 1'b0;
         else if (fifo_dropped) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         note_out  <= '0;
         note_on   <= 1'b0;
         dur_cnt   <= '0;
         gap_cnt   <= '0;
         presc_cnt <= '0;
      end else begin
         state     <= state_n;
         note_out  <= note_out_n;
         note_on   <= note_on_n;
         dur_cnt   <= dur_n;
         gap_cnt   <= gap_n;
         presc_cnt <= presc_n;
      end
   end

   always_comb begin
      state_n     = state;
      note_out_n  = note_out;
      note_on_n   = note_on;
      dur_n       = dur_cnt;
      gap_n       = gap_cnt;
      presc_n     = tick ? '0 : presc_cnt + 1'b1;
      pop         = 1'b0;
      note_strobe = 1'b0;
      seq_done    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (eff_run && !fifo_empty && !flush_now) state_n = ST_LOAD;
         end
         ST_LOAD: begin
            pop         = 1'b1;
            note_strobe = 1'b1;
            note_out_n  = head_note;
            note_on_n   = (head_note != 8'd0);
            dur_n       = (head_dur == '0) ? DUR_W'(1) : head_dur;
            presc_n     = '0;
            state_n     = ST_PLAY;
         end
         ST_PLAY: begin
            if (tick) begin
               if (dur_cnt <= DUR_W'(1)) begin
                  note_on_n = 1'b0;
                  if (GAP_TICKS > 0) begin
                     state_n = ST_GAP;
                     gap_n   = GAP_W'(GAP_TICKS);
                     presc_n = '0;
                  end else begin
                     seq_done = 1'b1;
                  end
               end else begin
                  dur_n = dur_cnt - 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (tick) begin
               if (gap_cnt <= GAP_W'(1)) seq_done = 1'b1;
               else                      gap_n    = gap_cnt - 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // back-to-back notes skip IDLE; the last note leaves note_out parked at rest
      if (seq_done) begin
         if (eff_run && !fifo_empty) begin
            state_n = ST_LOAD;
         end else begin
            state_n    = ST_IDLE;
            note_out_n = '0;
         end
      end

      if (abort) begin
         state_n     = ST_IDLE;
         note_out_n  = '0;
         note_on_n   = 1'b0;
         pop         = 1'b0;
         note_strobe = 1'b0;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL: begin
            readdata[CTRL_RUN]    = run;
            readdata[CTRL_IRQ_EN] = irq_en;
         end
         ADDR_DIV:  readdata[TICK_W-1:0] = div;
         ADDR_STAT: begin
            readdata[STAT_EMPTY]                = fifo_empty;
            readdata[STAT_FULL]                 = fifo_full;
            readdata[STAT_PLAYING]              = (state != ST_IDLE);
            readdata[STAT_OVERFLOW]             = overflow;
            readdata[STAT_COUNT_LSB +: CW]      = fifo_count;
         end
         default: readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_music_sheet_sequencer.sv
// tb/tb_music_sheet_sequencer.sv - self-checking bench for music_sheet_sequencer
module tb_music_sheet_sequencer;

   localparam int GAP   = 1;
   localparam int DEPTH = 16;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  note_out;
   logic        note_on;
   logic        note_strobe;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   music_sheet_sequencer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .note_out    (note_out),
      .note_on     (note_on),
      .note_strobe (note_strobe),
      .irq         (irq)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // phase: 0 silent, 1 fetching, 2 sounding, 3 inter-note gap
   int          m_phase;
   logic [23:0] m_q[$];
   int          m_left;
   logic [7:0]  m_note;
   bit          m_on, m_run, m_irq_en, m_ovf;
   logic [23:0] m_div;
   bit          mw, mfl, mer, mab, mpop, mdone;
   int          msz, mdiv, mdur;
   logic [23:0] mhead;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_flush_now();
      return chipselect && !write_n && address == 2'd1 && writedata[1];
   endfunction

   function automatic bit m_eff_run();
      if (chipselect && !write_n && address == 2'd1) return writedata[0];
      return m_run;
   endfunction

   function automatic bit m_abort();
      return (m_phase != 0) && (!m_eff_run() || m_flush_now());
   endfunction

   function automatic logic [31:0] m_readdata(input logic [1:0] a);
      logic [7:0] c;
      c = 8'(m_q.size());
      case (a)
         2'd1:    return {29'b0, m_irq_en, 1'b0, m_run};
         2'd2:    return {8'b0, m_div};
         2'd3:    return {16'b0, c, 4'b0, m_ovf, m_phase != 0, m_q.size() == DEPTH, m_q.size() == 0};
         default: return 32'b0;
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_phase = 0; m_q.delete(); m_left = 0; m_note = 0; m_on = 0;
         m_run = 0; m_irq_en = 0; m_div = 24'd50000; m_ovf = 0;
      end else begin
         mw    = chipselect && !write_n;
         mfl   = m_flush_now();
         mer   = m_eff_run();
         mab   = m_abort();
         msz   = m_q.size();
         mhead = (msz > 0) ? m_q[0] : 24'b0;
         mdiv  = (m_div == 0) ? 1 : int'(m_div);
         mpop  = 0;
         mdone = 0;
         if (mab) begin
            m_phase = 0; m_note = 0; m_on = 0;
         end else begin
            case (m_phase)
               0: if (mer && msz > 0 && !mfl) m_phase = 1;
               1: begin
                  mpop    = 1;
                  m_note  = mhead[7:0];
                  m_on    = (mhead[7:0] != 0);
                  mdur    = int'(mhead[23:8]);
                  if (mdur == 0) mdur = 1;
                  m_left  = mdur * mdiv;
                  m_phase = 2;
               end
               2: begin
                  m_left--;
                  if (m_left == 0) begin
                     m_on = 0;
                     if (GAP > 0) begin m_phase = 3; m_left = GAP * mdiv; end
                     else mdone = 1;
                  end
               end
               default: begin
                  m_left--;
                  if (m_left == 0) mdone = 1;
               end
            endcase
         end
         if (mdone) begin
            if (mer && msz > 0) m_phase = 1;
            else begin m_phase = 0; m_note = 0; end
         end
         if (mfl) m_q.delete();
         else begin
            if (mpop) void'(m_q.pop_front());
            if (mw && address == 2'd0) begin
               if (m_q.size() < DEPTH) m_q.push_back(writedata[23:0]);
               else m_ovf = 1;
            end
         end
         if (mw && address == 2'd1) begin m_run = writedata[0]; m_irq_en = writedata[2]; end
         if (mw && address == 2'd2) m_div = writedata[23:0];
         if (mw && address == 2'd3) m_ovf = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("note_out", {24'b0, note_out}, {24'b0, m_note});
         chk("note_on", {31'b0, note_on}, {31'b0, m_on});
         chk("note_strobe", {31'b0, note_strobe}, {31'b0, (m_phase == 1) && !m_abort()});
         chk("irq", {31'b0, irq}, {31'b0, m_irq_en && m_q.size() == 0 && m_phase == 0});
         chk("readdata", readdata, m_readdata(address));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1; write_n = 0;
      step();
      chipselect = 0; write_n = 1;
   endtask

   task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string nm);
      address = a; chipselect = 1; write_n = 1;
      #1;
      chk(nm, readdata, exp);
      chipselect = 0;
   endtask

   task automatic wait_idle();
      int k = 0;
      address = 2'd3;
      #1;
      while (readdata[2] && k < 3000) begin step(); k++; end
      chk("wait_idle_timeout", {31'b0, readdata[2]}, 32'd0);
   endtask

   task automatic wait_on(input string nm);
      int k = 0;
      while (!note_on && k < 500) begin step(); k++; end
      chk(nm, {31'b0, note_on}, 32'd1);
   endtask

   task automatic wait_strobe(input string nm);
      int k = 0;
      while (!note_strobe && k < 500) begin step(); k++; end
      chk(nm, {31'b0, note_strobe}, 32'd1);
   endtask

   initial begin
      int cnt;
      int seen;
      logic [7:0] seq_note [3];
      logic       seq_on   [3];
      int r;
      logic [7:0] nt;

      reset_n = 0; address = 0; chipselect = 0; write_n = 1; writedata = 0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1;
      chk_en = 1;
      step();

      // reset state
      rd_chk(2'd1, 32'd0, "reset_ctrl");
      rd_chk(2'd2, 32'd50000, "reset_div");
      rd_chk(2'd3, 32'h1, "reset_stat");
      chk("reset_note_on", {31'b0, note_on}, 32'd0);
      chk("reset_irq", {31'b0, irq}, 32'd0);

      // single note: latency, duration and gap length
      wr(2'd2, 32'd4);
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h0000_0340);
      chk("lat_no_strobe_yet", {31'b0, note_strobe}, 32'd0);
      step();
      chk("lat_strobe_2cyc", {31'b0, note_strobe}, 32'd1);
      step();
      cnt = 0;
      while (note_on && cnt < 100) begin cnt++; step(); end
      chk("note_on_cycles", cnt, 32'd12);
      address = 2'd3;
      #1;
      cnt = 0;
      while (readdata[2] && cnt < 100) begin cnt++; step(); end
      chk("gap_cycles", cnt, 32'd4);
      chk("irq_off_when_disabled", {31'b0, irq}, 32'd0);
      wr(2'd1, 32'd5);
      chk("irq_on_when_enabled", {31'b0, irq}, 32'd1);

      // overflow
      wr(2'd1, 32'd0);
      for (int i = 0; i < 17; i++) wr(2'd0, 32'h0000_0101 + i);
      rd_chk(2'd3, 32'h0000_100A, "full_overflow_stat");
      wr(2'd3, 32'd0);
      rd_chk(2'd3, 32'h0000_1002, "overflow_cleared");

      // note, rest, note
      wr(2'd1, 32'd2);
      rd_chk(2'd3, 32'h1, "flush_empty");
      wr(2'd2, 32'd2);
      wr(2'd0, 32'h0000_023C);
      wr(2'd0, 32'h0000_0100);
      wr(2'd0, 32'h0000_0243);
      wr(2'd1, 32'd1);
      seen = 0;
      cnt = 0;
      while (seen < 3 && cnt < 300) begin
         if (note_strobe) begin
            step();
            seq_note[seen] = note_out;
            seq_on[seen]   = note_on;
            seen++;
         end else step();
         cnt++;
      end
      chk("seq_strobes", seen, 32'd3);
      chk("seq_note0", {24'b0, seq_note[0]}, 32'h3C);
      chk("seq_note1", {24'b0, seq_note[1]}, 32'h00);
      chk("seq_note2", {24'b0, seq_note[2]}, 32'h43);
      chk("seq_rest_silent", {31'b0, seq_on[1]}, 32'd0);
      chk("seq_note_sounds", {31'b0, seq_on[2]}, 32'd1);
      wait_idle();

      // abort mid-note keeps queue, resume plays next entry
      wr(2'd0, 32'h0000_0550);
      wr(2'd0, 32'h0000_0551);
      wait_on("abort_wait_on");
      step(); step(); step();
      wr(2'd1, 32'd0);
      chk("abort_note_on", {31'b0, note_on}, 32'd0);
      chk("abort_note_out", {24'b0, note_out}, 32'd0);
      rd_chk(2'd3, 32'h0000_0100, "abort_stat");
      wr(2'd1, 32'd1);
      wait_strobe("resume_strobe");
      step();
      chk("resume_note", {24'b0, note_out}, 32'h51);
      wait_idle();

      // flush a full queue, then a zero-duration note
      wr(2'd1, 32'd0);
      for (int i = 0; i < 16; i++) wr(2'd0, 32'h0000_0112);
      rd_chk(2'd3, 32'h0000_1002, "full_stat");
      wr(2'd1, 32'd2);
      rd_chk(2'd3, 32'h1, "flushed_stat");
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (note_strobe) cnt++;
         step();
      end
      chk("no_strobe_after_flush", cnt, 32'd0);
      wr(2'd2, 32'd3);
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h0000_0070);
      wait_on("dur0_wait_on");
      cnt = 0;
      while (note_on && cnt < 100) begin cnt++; step(); end
      chk("dur0_one_tick", cnt, 32'd3);
      wait_idle();

      // randomized traffic
      wr(2'd1, 32'd0);
      wr(2'd2, 32'd2);
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 55) begin
            address = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n = 1;
            step();
         end else if (r < 80) begin
            nt = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            wr(2'd0, {8'($urandom), 8'($urandom_range(0, 3)), nt});
         end else if (r < 93) begin
            wr(2'd1, {29'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 9) != 0)});
         end else begin
            wr(2'd3, $urandom);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
